// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, logic/shift/move results and the HI/LO pair.
// Define DIV_UNIT_EN to include the iterative DIV/DIVU divider and its stall request.
module ex_stage #(
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int DIV_CYC  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic [ALUSEL_W-1:0] id_alusel_i,
  input  logic [31:0]         id_reg1_i,
  input  logic [31:0]         id_reg2_i,
  input  logic [4:0]          id_wd_i,
  input  logic                id_wreg_i,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [31:0]         wdata_o,
  output logic                stallreq_o,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o
);

  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'h24);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'h25);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'h26);
  localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'h27);
  localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8'h7C);
  localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8'h02);
  localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8'h03);
  localparam logic [ALUOP_W-1:0] OP_MFHI = ALUOP_W'(8'h10);
  localparam logic [ALUOP_W-1:0] OP_MFLO = ALUOP_W'(8'h12);
  localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'h1A);
  localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(8'h1B);

  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);
  localparam logic [ALUSEL_W-1:0] SEL_MOVE  = ALUSEL_W'(3'b011);

  logic [ALUOP_W-1:0]  aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic [31:0]         reg1, reg2;
  logic [4:0]          wd;
  logic                wreg;
  logic [31:0]         hi, lo;
  logic [31:0]         logic_res, shift_res, move_res;
  logic                is_div;

  // Flush inserts a bubble and beats stall; otherwise stall holds the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluop  <= '0;
      alusel <= '0;
      reg1   <= '0;
      reg2   <= '0;
      wd     <= '0;
      wreg   <= 1'b0;
    end else if (flush_i) begin
      aluop  <= '0;
      alusel <= '0;
      reg1   <= '0;
      reg2   <= '0;
      wd     <= '0;
      wreg   <= 1'b0;
    end else if (!stall_i) begin
      aluop  <= id_aluop_i;
      alusel <= id_alusel_i;
      reg1   <= id_reg1_i;
      reg2   <= id_reg2_i;
      wd     <= id_wd_i;
      wreg   <= id_wreg_i;
    end
  end

  assign is_div = (aluop == OP_DIV) || (aluop == OP_DIVU);

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    move_res  = '0;
    case (aluop)
      OP_OR:   logic_res = reg1 | reg2;
      OP_AND:  logic_res = reg1 & reg2;
      OP_XOR:  logic_res = reg1 ^ reg2;
      OP_NOR:  logic_res = ~(reg1 | reg2);
      OP_SLL:  shift_res = reg2 << reg1[4:0];
      OP_SRL:  shift_res = reg2 >> reg1[4:0];
      OP_SRA:  shift_res = $unsigned($signed(reg2) >>> reg1[4:0]);
      OP_MFHI: move_res  = hi;
      OP_MFLO: move_res  = lo;
      default: ;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    case (alusel)
      SEL_LOGIC: wdata_o = logic_res;
      SEL_SHIFT: wdata_o = shift_res;
      SEL_MOVE:  wdata_o = move_res;
      default:   wdata_o = '0;
    endcase
  end

  assign wd_o   = wd;
  assign wreg_o = wreg & ~is_div;
  assign hi_o   = hi;
  assign lo_o   = lo;

`ifdef DIV_UNIT_EN
  localparam int CNT_W = $clog2(DIV_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state;
  logic        done_flag, neg_q, neg_r, zero_div;
  logic [31:0] quo, rem, den;
  logic [CNT_W-1:0] cnt;
  logic        signed_op, neg1, neg2;
  logic [31:0] abs1, abs2;
  logic [32:0] trial, diff;

  always_comb begin
    signed_op = (aluop == OP_DIV);
    neg1      = signed_op & reg1[31];
    neg2      = signed_op & reg2[31];
    abs1      = neg1 ? (~reg1 + 32'd1) : reg1;
    abs2      = neg2 ? (~reg2 + 32'd1) : reg2;
    trial     = {rem, quo[31]};
    diff      = trial - {1'b0, den};
  end

  assign stallreq_o = is_div & ~done_flag & (state != DONE);

  // done_flag survives only while the same div is held in ID/EX, so it is never re-issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      done_flag <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_div  <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      den       <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (flush_i || !stall_i)
        done_flag <= 1'b0;
      else if (state == DONE)
        done_flag <= 1'b1;
      case (state)
        IDLE: begin
          if (is_div && !done_flag && !flush_i) begin
            if (reg2 == 32'd0) begin
              quo      <= '1;
              rem      <= reg1;
              zero_div <= 1'b1;
              state    <= DONE;
            end else begin
              quo      <= abs1;
              rem      <= '0;
              den      <= abs2;
              neg_q    <= neg1 ^ neg2;
              neg_r    <= neg1;
              zero_div <= 1'b0;
              cnt      <= '0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_CYC - 1))
              state <= DONE;
          end
        end
        DONE: begin
          if (zero_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= neg_r ? (~rem + 32'd1) : rem;
            lo <= neg_q ? (~quo + 32'd1) : quo;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign stallreq_o = 1'b0;
  assign hi         = '0;
  assign lo         = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divider checks only when DIV_UNIT_EN is defined.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_tb, flush_tb, stall;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1, id_reg2;
  logic [4:0]  id_wd;
  logic        id_wreg;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] wdata, hi, lo;
  logic        stallreq;
  int          compared = 0;
  int          mismatched = 0;

  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MFLO = 8'h12, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
  localparam logic [2:0] SEL_NONE = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_MOVE = 3'b011;

  always #5 clk = ~clk;

  assign stall = stall_tb | stallreq;

  ex_stage #(.ALUOP_W(8), .ALUSEL_W(3), .DIV_CYC(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush_tb),
    .id_aluop_i(id_aluop), .id_alusel_i(id_alusel),
    .id_reg1_i(id_reg1), .id_reg2_i(id_reg2),
    .id_wd_i(id_wd), .id_wreg_i(id_wreg),
    .wd_o(wd), .wreg_o(wreg), .wdata_o(wdata),
    .stallreq_o(stallreq), .hi_o(hi), .lo_o(lo)
  );

  task automatic set_inputs(input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [4:0] d, input logic w);
    id_aluop  = op;
    id_alusel = sel;
    id_reg1   = r1;
    id_reg2   = r2;
    id_wd     = d;
    id_wreg   = w;
  endtask

  // Present a decoded op and return at the negedge after it has entered EX.
  task automatic apply_stimulus(input logic [7:0] op, input logic [2:0] sel,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] d, input logic w);
    set_inputs(op, sel, r1, r2, d, w);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Count negedges with stallreq high, bounded so a stuck divider still ends the run.
  task automatic count_stall(output int cycles);
    cycles = 0;
    while (stallreq && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cycles;
    rst      = 1'b0;
    stall_tb = 1'b0;
    flush_tb = 1'b0;
    set_inputs(8'h00, SEL_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    check_output("reset_wdata", wdata, 32'h0);
    check_output("reset_wd", {27'd0, wd}, 32'h0);
    check_output("reset_wreg", {31'd0, wreg}, 32'h0);
    check_output("reset_stallreq", {31'd0, stallreq}, 32'h0);
    check_output("reset_hi", hi, 32'h0);
    check_output("reset_lo", lo, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] logic ops");
    apply_stimulus(OP_OR, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd5, 1'b1);
    check_output("or_wdata", wdata, 32'h00FFF0FF);
    check_output("or_wd", {27'd0, wd}, 32'd5);
    check_output("or_wreg", {31'd0, wreg}, 32'd1);
    apply_stimulus(OP_AND, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd6, 1'b1);
    check_output("and_wdata", wdata, 32'h000000F0);
    apply_stimulus(OP_XOR, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd7, 1'b1);
    check_output("xor_wdata", wdata, 32'h00FFF00F);
    apply_stimulus(OP_NOR, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd8, 1'b0);
    check_output("nor_wdata", wdata, 32'hFF000F00);
    check_output("nor_wreg", {31'd0, wreg}, 32'd0);

    $display("[TB] shifts");
    apply_stimulus(OP_SRA, SEL_SHIFT, 32'd4, 32'h80000000, 5'd9, 1'b1);
    check_output("sra_wdata", wdata, 32'hF8000000);
    apply_stimulus(OP_SRL, SEL_SHIFT, 32'd4, 32'h80000000, 5'd9, 1'b1);
    check_output("srl_wdata", wdata, 32'h08000000);
    apply_stimulus(OP_SLL, SEL_SHIFT, 32'd31, 32'h00000001, 5'd9, 1'b1);
    check_output("sll_wdata", wdata, 32'h80000000);
    apply_stimulus(OP_SRA, SEL_SHIFT, 32'd8, 32'h7F000000, 5'd9, 1'b1);
    check_output("sra_pos_wdata", wdata, 32'h007F0000);

    $display("[TB] select boundaries");
    apply_stimulus(OP_OR, SEL_NONE, 32'h0000F0F0, 32'h00FF00FF, 5'd1, 1'b1);
    check_output("sel_none_wdata", wdata, 32'h0);
    apply_stimulus(8'h55, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd1, 1'b1);
    check_output("bad_op_wdata", wdata, 32'h0);
    apply_stimulus(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd2, 1'b1);
    check_output("mfhi_reset_wdata", wdata, 32'h0);

    $display("[TB] stall and flush");
    apply_stimulus(OP_OR, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd5, 1'b1);
    stall_tb = 1'b1;
    apply_stimulus(OP_AND, SEL_LOGIC, 32'h12345678, 32'h0F0F0F0F, 5'd11, 1'b1);
    check_output("stall_hold_wdata", wdata, 32'h00FFF0FF);
    check_output("stall_hold_wd", {27'd0, wd}, 32'd5);
    flush_tb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("flush_wdata", wdata, 32'h0);
    check_output("flush_wreg", {31'd0, wreg}, 32'd0);
    stall_tb = 1'b0;
    flush_tb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("after_stall_wdata", wdata, 32'h02040608);

    $display("[TB] asynchronous reset");
    apply_stimulus(OP_AND, SEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd3, 1'b1);
    check_output("pre_reset_wdata", wdata, 32'h000000F0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_output("async_rst_wdata", wdata, 32'h0);
    check_output("async_rst_wreg", {31'd0, wreg}, 32'h0);
    check_output("async_rst_wd", {27'd0, wd}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    set_inputs(8'h00, SEL_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);

`ifdef DIV_UNIT_EN
    $display("[TB] divider enabled");
    apply_stimulus(OP_DIVU, SEL_NONE, 32'd100, 32'd7, 5'd4, 1'b1);
    check_output("divu_wreg", {31'd0, wreg}, 32'd0);
    set_inputs(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd10, 1'b1);
    count_stall(cycles);
    check_output("divu_stall_cycles", cycles, 32'd33);
    @(negedge clk);
    check_output("divu_mflo_wdata", wdata, 32'd14);
    check_output("divu_lo", lo, 32'd14);
    check_output("divu_hi", hi, 32'd2);

    apply_stimulus(OP_DIV, SEL_NONE, 32'hFFFFFFF9, 32'd2, 5'd4, 1'b1);
    set_inputs(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd10, 1'b1);
    count_stall(cycles);
    check_output("div_stall_cycles", cycles, 32'd33);
    @(negedge clk);
    check_output("div_mflo_wdata", wdata, 32'hFFFFFFFD);
    check_output("div_hi", hi, 32'hFFFFFFFF);

    apply_stimulus(OP_DIVU, SEL_NONE, 32'h00001234, 32'd0, 5'd4, 1'b1);
    set_inputs(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd10, 1'b1);
    count_stall(cycles);
    check_output("div0_stall_cycles", cycles, 32'd1);
    @(negedge clk);
    check_output("div0_mfhi_wdata", wdata, 32'h00001234);
    check_output("div0_lo", lo, 32'hFFFFFFFF);

    apply_stimulus(OP_DIVU, SEL_NONE, 32'd100, 32'd7, 5'd4, 1'b1);
    set_inputs(8'h00, SEL_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (10) @(negedge clk);
    check_output("busy_stallreq", {31'd0, stallreq}, 32'd1);
    flush_tb = 1'b1;
    @(negedge clk);
    flush_tb = 1'b0;
    check_output("abort_stallreq", {31'd0, stallreq}, 32'd0);
    repeat (40) @(negedge clk);
    check_output("abort_hi", hi, 32'h00001234);
    check_output("abort_lo", lo, 32'hFFFFFFFF);
`else
    $display("[TB] divider disabled");
    apply_stimulus(OP_DIV, SEL_NONE, 32'd100, 32'd7, 5'd4, 1'b1);
    check_output("nodiv_stallreq", {31'd0, stallreq}, 32'd0);
    check_output("nodiv_wreg", {31'd0, wreg}, 32'd0);
    check_output("nodiv_wd", {27'd0, wd}, 32'd4);
    apply_stimulus(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd10, 1'b1);
    check_output("nodiv_mflo_wdata", wdata, 32'h0);
    check_output("nodiv_hi", hi, 32'h0);
    check_output("nodiv_lo", lo, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
